// File: rtl/btn_input_if_if.sv
// Bus-side signals between the Bridge and the push-button peripheral.
// The Bridge is the master. The button block answers as the slave, with combinational rdata and irq.
interface btn_input_if_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/btn_input_if.sv
// Push-button input peripheral: 2-flop synchroniser, per-bit debounce,
// press-event pending register (write-1-to-clear) and a wrapping press counter.
module btn_input_if #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [4:0]     button,
    btn_input_if_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       s1_reg;
    logic [4:0]       s2_reg;
    logic [4:0]       stable_reg;
    logic [4:0]       stable_next;
    logic [4:0]       pending_reg;
    logic [4:0]       pending_next;
    logic [7:0]       press_cnt_reg;
    logic [7:0]       press_cnt_next;
    logic [CNT_W-1:0] cnt_reg  [5];
    logic [CNT_W-1:0] cnt_next [5];
    logic [4:0]       rise;
    logic [2:0]       rise_count;
    logic             w1c_pending;
    logic             clr_press_cnt;

    // Only addr[3:2] and wdata[4:0] carry meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:5]};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
            logic differs;
            logic at_limit;
            assign differs         = s2_reg[gi] != stable_reg[gi];
            assign at_limit        = cnt_reg[gi] == CNT_LAST;
            assign cnt_next[gi]    = (!differs || at_limit) ? '0 : cnt_reg[gi] + CNT_W'(1);
            assign stable_next[gi] = (differs && at_limit) ? s2_reg[gi] : stable_reg[gi];
            assign rise[gi]        = differs && at_limit && s2_reg[gi];
        end
    endgenerate

    always_comb begin
        rise_count = '0;
        for (int i = 0; i < 5; i++) begin
            rise_count = rise_count + 3'(rise[i]);
        end
    end

    assign w1c_pending   = bus.we && (bus.addr[3:2] == 2'b01);
    assign clr_press_cnt = bus.we && (bus.addr[3:2] == 2'b10);

    // New rises are OR'd in after the clear, so a same-edge press always survives.
    assign pending_next   = (w1c_pending ? (pending_reg & ~bus.wdata[4:0]) : pending_reg) | rise;
    assign press_cnt_next = (clr_press_cnt ? 8'd0 : press_cnt_reg) + {5'd0, rise_count};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_reg        <= '0;
            s2_reg        <= '0;
            stable_reg    <= '0;
            pending_reg   <= '0;
            press_cnt_reg <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            s1_reg        <= button;
            s2_reg        <= s1_reg;
            stable_reg    <= stable_next;
            pending_reg   <= pending_next;
            press_cnt_reg <= press_cnt_next;
            for (int i = 0; i < 5; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        case (bus.addr[3:2])
            2'b00:   bus.rdata = {27'd0, stable_reg};
            2'b01:   bus.rdata = {27'd0, pending_reg};
            2'b10:   bus.rdata = {24'd0, press_cnt_reg};
            default: bus.rdata = 32'h0;
        endcase
    end

    assign bus.irq = |pending_reg;

endmodule

// File: tb/tb_btn_input_if.sv
// Directed bench for btn_input_if with DEBOUNCE_CYCLES=4: vector table plus
// hand-written sequences for reset latency, glitch rejection, set-vs-clear and counter wrap.
module tb_btn_input_if;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] button;
    int         checks   = 0;
    int         failures = 0;

    btn_input_if_if bus ();

    btn_input_if #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .button (button),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  button;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          cycles;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [12];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s got=%h", name, got);
        end
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rdata, exp);
    endtask

    task automatic irq_check(input string name, input logic exp);
        check(name, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick(1);
        bus.we    = 1'b0;
    endtask

    task automatic run_vec(input int i);
        bus.addr  = vecs[i].waddr;
        bus.wdata = vecs[i].wdata;
        bus.we    = vecs[i].we;
        button    = vecs[i].button;
        if (vecs[i].cycles > 0) begin
            tick(1);
            bus.we = 1'b0;
            tick(vecs[i].cycles - 1);
        end
        rd_check($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
        irq_check($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    endtask

    initial begin
        // button, we, waddr, wdata, cycles, raddr, exp_rdata, exp_irq
        vecs[0]  = '{5'h00, 1'b0, 32'h0,         32'h0,         8,  32'h0, 32'h00, 1'b1};
        vecs[1]  = '{5'h00, 1'b1, 32'h4,         32'hFFFF_FFFF, 1,  32'h4, 32'h00, 1'b0};
        vecs[2]  = '{5'h00, 1'b1, 32'h8,         32'h0,         1,  32'h8, 32'h00, 1'b0};
        vecs[3]  = '{5'h13, 1'b0, 32'h0,         32'h0,         10, 32'h0, 32'h13, 1'b1};
        vecs[4]  = '{5'h00, 1'b0, 32'h0,         32'h0,         8,  32'h0, 32'h00, 1'b1};
        vecs[5]  = '{5'h00, 1'b0, 32'h0,         32'h0,         0,  32'h4, 32'h13, 1'b1};
        vecs[6]  = '{5'h00, 1'b0, 32'h0,         32'h0,         0,  32'h8, 32'h04, 1'b1};
        vecs[7]  = '{5'h00, 1'b1, 32'h1000_0004, 32'h3,         1,  32'h4, 32'h10, 1'b1};
        vecs[8]  = '{5'h00, 1'b1, 32'h4,         32'h10,        1,  32'h4, 32'h00, 1'b0};
        vecs[9]  = '{5'h00, 1'b1, 32'h0,         32'hFF,        1,  32'h8, 32'h04, 1'b0};
        vecs[10] = '{5'h00, 1'b1, 32'hC,         32'hFF,        1,  32'h8, 32'h04, 1'b0};
        vecs[11] = '{5'h00, 1'b0, 32'h0,         32'h0,         0,  32'hC, 32'h00, 1'b0};

        rstn      = 1'b0;
        button    = 5'h1F;
        bus.addr  = 32'h0;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;

        // Reset state with all buttons held
        tick(3);
        rd_check("rst_addr0", 32'h0, 32'h0);
        rd_check("rst_addr4", 32'h4, 32'h0);
        rd_check("rst_addr8", 32'h8, 32'h0);
        irq_check("rst_irq", 1'b0);
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd_check($sformatf("rst_lat_e%0d", k), 32'h0, (k == 6) ? 32'h1F : 32'h0);
        end
        rd_check("rst_pending", 32'h4, 32'h1F);
        rd_check("rst_cnt", 32'h8, 32'h05);
        irq_check("rst_irq_set", 1'b1);

        for (int i = 0; i < 3; i++) run_vec(i);

        // Three-cycle glitch on button[0] must be rejected
        button = 5'h01;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) button = 5'h00;
            tick(1);
            rd_check($sformatf("glitch_e%0d", k), 32'h0, 32'h0);
        end
        rd_check("glitch_pending", 32'h4, 32'h0);
        button = 5'h01;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd_check($sformatf("press_e%0d", k), 32'h0, (k == 6) ? 32'h1 : 32'h0);
        end
        tick(4);
        rd_check("press_pending", 32'h4, 32'h1);
        rd_check("press_cnt", 32'h8, 32'h1);
        button = 5'h00;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd_check($sformatf("release_e%0d", k), 32'h0, (k == 6) ? 32'h0 : 32'h1);
        end
        rd_check("release_pending", 32'h4, 32'h1);
        rd_check("release_cnt", 32'h8, 32'h1);

        for (int i = 3; i < 12; i++) run_vec(i);

        // button[2] rise lands on the same edge as a W1C of bit 2
        button = 5'h04;
        tick(5);
        rd_check("sbc_pre_stable", 32'h0, 32'h0);
        rd_check("sbc_pre_pending", 32'h4, 32'h0);
        wr(32'h4, 32'h4);
        rd_check("sbc_stable", 32'h0, 32'h4);
        rd_check("sbc_pending", 32'h4, 32'h4);
        irq_check("sbc_irq", 1'b1);
        button = 5'h00;
        tick(8);
        wr(32'h4, 32'h4);
        rd_check("sbc_cleared", 32'h4, 32'h0);

        // 257 presses on button[1] wrap the counter to 1
        wr(32'h8, 32'h0);
        rd_check("wrap_clr", 32'h8, 32'h0);
        for (int p = 0; p < 257; p++) begin
            button = 5'h02;
            tick(6);
            button = 5'h00;
            tick(6);
        end
        rd_check("wrap_cnt", 32'h8, 32'h1);
        rd_check("wrap_pending", 32'h4, 32'h2);
        wr(32'h8, 32'h0);
        rd_check("clr_no_rise", 32'h8, 32'h0);
        button = 5'h08;
        tick(5);
        wr(32'h8, 32'h0);
        rd_check("clr_with_rise", 32'h8, 32'h1);
        rd_check("clr_rise_stable", 32'h0, 32'h8);
        rd_check("clr_rise_pending", 32'h4, 32'hA);
        wr(32'h0, 32'hFF);
        rd_check("wr0_pending", 32'h4, 32'hA);
        rd_check("wr0_cnt", 32'h8, 32'h1);
        rd_check("wr0_stable", 32'h0, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
